// File: rtl/counter_readout_sequencer_pkg.sv
// Shared types and constants for the counter readout sequencer.
// Holds the FSM state enum, channel/byte geometry, the default flag
// signature and a helper producing an active-low one-hot byte select.
package counter_readout_sequencer_pkg;

  localparam int unsigned NUM_CH        = 8;
  localparam int unsigned BYTES_PER_CNT = 4;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned CH_W          = 3;
  localparam int unsigned BIDX_W        = 2;
  localparam int unsigned SETTLE_W      = 4;
  localparam int unsigned CNT_W_DEF     = 27;

  localparam logic [BYTE_W-1:0] DEF_SIGNATURE = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLAG   = 3'd1,
    ST_GAP    = 3'd2,
    ST_NEXTCH = 3'd3,
    ST_BYTE   = 3'd4,
    ST_PUSH   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Active-low select with only byte 'idx' pulled low.
  function automatic logic [BYTES_PER_CNT-1:0] byte_sel_n(input logic [BIDX_W-1:0] idx);
    byte_sel_n = ~(BYTES_PER_CNT'(1) << idx);
  endfunction

endpackage

// File: rtl/select_strobe_timer.sv
// Settle-cycle counter shared by the flag check and byte reads.
// While run_i is held, counts SETTLE_CYCLES cycles and then raises
// sample_c_o (combinational) for the cycle whose closing edge samples the bus.
// Ports: clk, reset (sync, active-high), run_i (select window active),
//        sample_c_o (capture on the coming edge).
module select_strobe_timer
  import counter_readout_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic sample_c_o
);

  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;
  logic                at_end;

  assign at_end     = (cnt_q == SETTLE_W'(SETTLE_CYCLES));
  assign sample_c_o = run_i && at_end;

  // Restart from zero whenever the window closes or completes.
  always_comb begin
    cnt_d = '0;
    if (run_i && !at_end) begin
      cnt_d = cnt_q + SETTLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_readout_sequencer.sv
// Bus-master reader for the 8-channel counter register interface.
// On start: checks the flag signature, then for each enabled channel walks
// the four active-low byte selects, reassembles the 27-bit count and offers
// it on a valid/ready port.
// Ports: clk, reset (sync, active-high), start, chan_mask,
//        sel_flag / sel_cntr_tbuf1..8 (active-low selects), tc_flag_in,
//        count_in1..8, rd_data/rd_chan/rd_valid/rd_ready (result port),
//        busy, done, sig_err, fmt_err (status).
module counter_readout_sequencer
  import counter_readout_sequencer_pkg::*;
#(
  parameter int unsigned       SETTLE_CYCLES = 2,
  parameter logic [BYTE_W-1:0] SIGNATURE     = DEF_SIGNATURE,
  parameter int unsigned       CNT_W         = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        chan_mask,
  output logic                     sel_flag,
  output logic [BYTES_PER_CNT-1:0] sel_cntr_tbuf1,
  output logic [BYTES_PER_CNT-1:0] sel_cntr_tbuf2,
  output logic [BYTES_PER_CNT-1:0] sel_cntr_tbuf3,
  output logic [BYTES_PER_CNT-1:0] sel_cntr_tbuf4,
  output logic [BYTES_PER_CNT-1:0] sel_cntr_tbuf5,
  output logic [BYTES_PER_CNT-1:0] sel_cntr_tbuf6,
  output logic [BYTES_PER_CNT-1:0] sel_cntr_tbuf7,
  output logic [BYTES_PER_CNT-1:0] sel_cntr_tbuf8,
  input  logic [BYTE_W-1:0]        tc_flag_in,
  input  logic [BYTE_W-1:0]        count_in1,
  input  logic [BYTE_W-1:0]        count_in2,
  input  logic [BYTE_W-1:0]        count_in3,
  input  logic [BYTE_W-1:0]        count_in4,
  input  logic [BYTE_W-1:0]        count_in5,
  input  logic [BYTE_W-1:0]        count_in6,
  input  logic [BYTE_W-1:0]        count_in7,
  input  logic [BYTE_W-1:0]        count_in8,
  output logic [CNT_W-1:0]         rd_data,
  output logic [CH_W-1:0]          rd_chan,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     sig_err,
  output logic                     fmt_err
);

  state_t state_q, state_d;
  state_t ret_q,   ret_d;    // where GAP goes next

  logic [NUM_CH-1:0]                     mask_q,   mask_d;
  logic [CH_W-1:0]                       chan_q,   chan_d;
  logic [BIDX_W-1:0]                     byte_q,   byte_d;
  logic [CNT_W-1:0]                      asm_q,    asm_d;
  logic                                  sig_err_q, sig_err_d;
  logic                                  fmt_err_q, fmt_err_d;
  logic                                  sel_flag_q, sel_flag_d;
  logic [NUM_CH-1:0][BYTES_PER_CNT-1:0]  sel_q,    sel_d;
  logic                                  rd_valid_q, rd_valid_d;
  logic                                  busy_q,   busy_d;
  logic                                  done_q,   done_d;

  logic [BYTE_W-1:0] cnt_bus [NUM_CH];
  logic [BYTE_W-1:0] cur_byte;
  logic [CH_W-1:0]   pe_idx;
  logic              pe_any;
  logic              sample;
  logic              timer_run;

  assign cnt_bus[0] = count_in1;
  assign cnt_bus[1] = count_in2;
  assign cnt_bus[2] = count_in3;
  assign cnt_bus[3] = count_in4;
  assign cnt_bus[4] = count_in5;
  assign cnt_bus[5] = count_in6;
  assign cnt_bus[6] = count_in7;
  assign cnt_bus[7] = count_in8;
  assign cur_byte   = cnt_bus[chan_q];

  assign timer_run = (state_q == ST_FLAG) || (state_q == ST_BYTE);

  select_strobe_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .run_i      (timer_run),
    .sample_c_o (sample)
  );

  // Lowest set bit of the remaining mask wins.
  always_comb begin
    pe_idx = '0;
    pe_any = |mask_q;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        pe_idx = CH_W'(i);
      end
    end
  end

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    mask_d    = mask_q;
    chan_d    = chan_q;
    byte_d    = byte_q;
    asm_d     = asm_q;
    sig_err_d = sig_err_q;
    fmt_err_d = fmt_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d    = chan_mask;
          sig_err_d = 1'b0;
          fmt_err_d = 1'b0;
          state_d   = ST_FLAG;
        end
      end
      ST_FLAG: begin
        if (sample) begin
          state_d = ST_GAP;
          if (tc_flag_in != SIGNATURE) begin
            sig_err_d = 1'b1;
            ret_d     = ST_DONE;
          end else begin
            ret_d     = ST_NEXTCH;
          end
        end
      end
      ST_GAP: begin
        state_d = ret_q;
        if (ret_q == ST_BYTE) begin
          byte_d = byte_q + BIDX_W'(1);
        end
      end
      ST_NEXTCH: begin
        if (!pe_any) begin
          state_d = ST_DONE;
        end else begin
          chan_d         = pe_idx;
          mask_d[pe_idx] = 1'b0;
          byte_d         = '0;
          state_d        = ST_BYTE;
        end
      end
      ST_BYTE: begin
        if (sample) begin
          case (byte_q)
            2'd0: asm_d[7:0]   = cur_byte;
            2'd1: asm_d[15:8]  = cur_byte;
            2'd2: asm_d[23:16] = cur_byte;
            default: begin
              // Top byte carries only three count bits; the rest must be zero.
              asm_d[26:24] = cur_byte[2:0];
              if (|cur_byte[7:3]) begin
                fmt_err_d = 1'b1;
              end
            end
          endcase
          state_d = ST_GAP;
          ret_d   = (byte_q == 2'd3) ? ST_PUSH : ST_BYTE;
        end
      end
      ST_PUSH: begin
        if (rd_ready) begin
          state_d = ST_NEXTCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values follow the next state so outputs align with state_q.
  always_comb begin
    sel_flag_d = (state_d != ST_FLAG);
    sel_d      = '1;
    if (state_d == ST_BYTE) begin
      sel_d[chan_d] = byte_sel_n(byte_d);
    end
    rd_valid_d = (state_d == ST_PUSH);
    busy_d     = !((state_d == ST_IDLE) || (state_d == ST_DONE));
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      mask_q     <= '0;
      chan_q     <= '0;
      byte_q     <= '0;
      asm_q      <= '0;
      sig_err_q  <= 1'b0;
      fmt_err_q  <= 1'b0;
      sel_flag_q <= 1'b1;
      sel_q      <= '1;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      mask_q     <= mask_d;
      chan_q     <= chan_d;
      byte_q     <= byte_d;
      asm_q      <= asm_d;
      sig_err_q  <= sig_err_d;
      fmt_err_q  <= fmt_err_d;
      sel_flag_q <= sel_flag_d;
      sel_q      <= sel_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sel_flag       = sel_flag_q;
  assign sel_cntr_tbuf1 = sel_q[0];
  assign sel_cntr_tbuf2 = sel_q[1];
  assign sel_cntr_tbuf3 = sel_q[2];
  assign sel_cntr_tbuf4 = sel_q[3];
  assign sel_cntr_tbuf5 = sel_q[4];
  assign sel_cntr_tbuf6 = sel_q[5];
  assign sel_cntr_tbuf7 = sel_q[6];
  assign sel_cntr_tbuf8 = sel_q[7];
  assign rd_data        = asm_q;
  assign rd_chan        = chan_q;
  assign rd_valid       = rd_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign sig_err        = sig_err_q;
  assign fmt_err        = fmt_err_q;

endmodule

// File: tb/tb_counter_readout_sequencer.sv
// Self-checking bench for counter_readout_sequencer: the bench emulates the
// counter register interface (bytes appear only while their select is low)
// and compares delivered results, status and sweep length against a model.
module tb_counter_readout_sequencer;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  chan_mask = 8'h00;
  logic        sel_flag;
  logic [3:0]  sel_arr [8];
  logic [7:0]  tc_flag_in;
  logic [7:0]  cin [8];
  logic [26:0] rd_data;
  logic [2:0]  rd_chan;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        busy, done, sig_err, fmt_err;

  logic [7:0]  flag_val = 8'hAA;
  logic [7:0]  bmem [8][4];
  logic        rdy_level = 1'b1;
  logic        rdy_rand = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;

  int          viol = 0;
  int          prev_id = 0;
  int          busy_cyc = 0;
  int          done_cnt = 0;
  bit          cntr_low_seen = 0;
  bit          valid_seen = 0;
  logic [29:0] got_q [$];
  logic [29:0] exp_q [$];
  bit          exp_fmt;

  always #5 clk = ~clk;

  counter_readout_sequencer #(
    .SETTLE_CYCLES (S),
    .SIGNATURE     (8'hAA),
    .CNT_W         (27)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .chan_mask      (chan_mask),
    .sel_flag       (sel_flag),
    .sel_cntr_tbuf1 (sel_arr[0]),
    .sel_cntr_tbuf2 (sel_arr[1]),
    .sel_cntr_tbuf3 (sel_arr[2]),
    .sel_cntr_tbuf4 (sel_arr[3]),
    .sel_cntr_tbuf5 (sel_arr[4]),
    .sel_cntr_tbuf6 (sel_arr[5]),
    .sel_cntr_tbuf7 (sel_arr[6]),
    .sel_cntr_tbuf8 (sel_arr[7]),
    .tc_flag_in     (tc_flag_in),
    .count_in1      (cin[0]),
    .count_in2      (cin[1]),
    .count_in3      (cin[2]),
    .count_in4      (cin[3]),
    .count_in5      (cin[4]),
    .count_in6      (cin[5]),
    .count_in7      (cin[6]),
    .count_in8      (cin[7]),
    .rd_data        (rd_data),
    .rd_chan        (rd_chan),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .busy           (busy),
    .done           (done),
    .sig_err        (sig_err),
    .fmt_err        (fmt_err)
  );

  // Register interface emulation: a bus shows data only while selected.
  assign tc_flag_in = sel_flag ? 8'h00 : flag_val;
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      cin[n] = 8'hEE;
      for (int k = 0; k < 4; k++) begin
        if (!sel_arr[n][k]) cin[n] = bmem[n][k];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
  end

  // Bus-discipline monitor and result collector.
  always @(negedge clk) begin
    int nlow;
    int cur;
    nlow = 0;
    cur  = 0;
    if (!sel_flag) begin nlow++; cur = 1; end
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 4; k++)
        if (!sel_arr[n][k]) begin nlow++; cur = 2 + n * 4 + k; end
    if (reset) begin
      prev_id = 0;
    end else begin
      if (nlow > 1) viol++;
      if (cur != 0 && prev_id != 0 && cur != prev_id) viol++;
      if (rd_valid && cur != 0) viol++;
      prev_id = cur;
      if (cur > 1) cntr_low_seen = 1;
      if (rd_valid) valid_seen = 1;
      if (rd_valid && rd_ready) got_q.push_back({rd_chan, rd_data});
      if (busy) busy_cyc++;
      if (done) done_cnt++;
    end
  end

  // Reference: enabled channels in ascending order, 27-bit value from bytes.
  function automatic void build_exp(input logic [7:0] m);
    exp_q.delete();
    exp_fmt = 0;
    for (int n = 0; n < 8; n++) begin
      if (m[n]) begin
        exp_q.push_back({3'(n), bmem[n][3][2:0], bmem[n][2], bmem[n][1], bmem[n][0]});
        if (bmem[n][3][7:3] != 5'd0) exp_fmt = 1;
      end
    end
  endfunction

  function automatic int exp_busy(input int nch, input bit sig_ok);
    exp_busy = sig_ok ? (S + 3 + nch * (4 * (S + 2) + 2)) : (S + 2);
  endfunction

  task automatic rand_bytes(input bit dirty_top);
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 4; k++) begin
        bmem[n][k] = 8'($urandom);
        if (k == 3 && !dirty_top) bmem[n][k][7:3] = 5'd0;
      end
  endtask

  task automatic clear_mon();
    got_q.delete();
    viol = 0; busy_cyc = 0; done_cnt = 0;
    cntr_low_seen = 0; valid_seen = 0;
  endtask

  task automatic pulse_start(input logic [7:0] m);
    @(posedge clk); #1;
    chan_mask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; chan_mask = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL %s_timeout: done=0 required 1", tag); end
    @(negedge clk);
  endtask

  task automatic check_results(input string tag);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL %s_count: got %0d results, required %0d", tag, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL %s_result%0d: got chan/data %h required %h", tag, i, got_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (viol !== 0) begin n_bad++; $display("FAIL %s_bus: %0d discipline violations, required 0", tag, viol); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (sel_flag !== 1'b1) begin n_bad++; $display("FAIL rst_sel_flag: got %b required 1", sel_flag); end
    n_cmp++; if ({sel_arr[0], sel_arr[1], sel_arr[2], sel_arr[3], sel_arr[4], sel_arr[5], sel_arr[6], sel_arr[7]} !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL rst_sel_cntr: not all high, required FFFFFFFF"); end
    n_cmp++; if ({rd_valid, busy, done, sig_err, fmt_err} !== 5'b0) begin
      n_bad++; $display("FAIL rst_status: got %b required 00000", {rd_valid, busy, done, sig_err, fmt_err}); end
    n_cmp++; if ({rd_chan, rd_data} !== 30'h0) begin n_bad++; $display("FAIL rst_data: got %h required 0", {rd_chan, rd_data}); end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_single();
    bmem[0][0] = 8'h21; bmem[0][1] = 8'h43; bmem[0][2] = 8'h65; bmem[0][3] = 8'h07;
    flag_val = 8'hAA; rdy_rand = 0; rdy_level = 1;
    clear_mon();
    pulse_start(8'h01);
    wait_done("single");
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse: done=%b one cycle later, required 0", done); end
    build_exp(8'h01);
    check_results("single");
    n_cmp++; if (got_q.size() == 1 && got_q[0] !== {3'd0, 27'h7654321}) begin
      n_bad++; $display("FAIL single_value: got %h required %h", got_q[0], {3'd0, 27'h7654321}); end
    n_cmp++; if ({sig_err, fmt_err} !== 2'b00) begin n_bad++; $display("FAIL single_err: got %b required 00", {sig_err, fmt_err}); end
    n_cmp++; if (busy_cyc !== exp_busy(1, 1)) begin n_bad++; $display("FAIL single_cycles: got %0d required %0d", busy_cyc, exp_busy(1, 1)); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL single_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_sig_err();
    flag_val = 8'h55;
    clear_mon();
    pulse_start(8'hFF);
    wait_done("sig");
    n_cmp++; if (sig_err !== 1'b1) begin n_bad++; $display("FAIL sig_err_flag: got %b required 1", sig_err); end
    n_cmp++; if (cntr_low_seen !== 1'b0) begin n_bad++; $display("FAIL sig_no_select: counter select went low, required never"); end
    n_cmp++; if (valid_seen !== 1'b0) begin n_bad++; $display("FAIL sig_no_valid: rd_valid seen 1, required never"); end
    n_cmp++; if (busy_cyc !== exp_busy(0, 0)) begin n_bad++; $display("FAIL sig_cycles: got %0d required %0d", busy_cyc, exp_busy(0, 0)); end
    flag_val = 8'hAA;
  endtask

  task automatic test_multi();
    rand_bytes(0);
    clear_mon();
    pulse_start(8'hA4);
    wait_done("multi");
    build_exp(8'hA4);
    check_results("multi");
    n_cmp++; if (busy_cyc !== exp_busy(3, 1)) begin n_bad++; $display("FAIL multi_cycles: got %0d required %0d", busy_cyc, exp_busy(3, 1)); end
    n_cmp++; if (sig_err !== 1'b0) begin n_bad++; $display("FAIL multi_sig: got %b required 0", sig_err); end
  endtask

  task automatic test_mask_zero();
    clear_mon();
    pulse_start(8'h00);
    wait_done("mask0");
    n_cmp++; if (busy_cyc !== exp_busy(0, 1)) begin n_bad++; $display("FAIL mask0_cycles: got %0d required %0d", busy_cyc, exp_busy(0, 1)); end
    n_cmp++; if (valid_seen !== 1'b0) begin n_bad++; $display("FAIL mask0_valid: rd_valid seen, required never"); end
  endtask

  task automatic test_fmt();
    rand_bytes(0);
    bmem[0][3] = 8'hF9;
    clear_mon();
    pulse_start(8'h01);
    wait_done("fmt");
    build_exp(8'h01);
    check_results("fmt");
    n_cmp++; if (rd_data[26:24] !== 3'b001) begin n_bad++; $display("FAIL fmt_top_bits: got %b required 001", rd_data[26:24]); end
    repeat (5) @(negedge clk);
    n_cmp++; if (fmt_err !== 1'b1) begin n_bad++; $display("FAIL fmt_sticky: got %b required 1", fmt_err); end
    bmem[0][3] = 8'h02;
    clear_mon();
    pulse_start(8'h01);
    @(negedge clk);
    n_cmp++; if (fmt_err !== 1'b0) begin n_bad++; $display("FAIL fmt_clear: got %b required 0", fmt_err); end
    wait_done("fmt2");
  endtask

  task automatic test_backpressure();
    bit seen;
    rand_bytes(0);
    build_exp(8'h41);
    rdy_level = 0;
    clear_mon();
    pulse_start(8'h41);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (rd_valid) seen = 1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_valid_timeout: rd_valid=0 required 1"); end
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (rd_valid !== 1'b1 || {rd_chan, rd_data} !== exp_q[0] || sel_flag !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold%0d: valid=%b chan/data=%h required 1/%h", c, rd_valid, {rd_chan, rd_data}, exp_q[0]);
      end
      @(negedge clk);
    end
    rdy_level = 1;
    wait_done("bp");
    check_results("bp");
  endtask

  task automatic test_reset_mid();
    bit seen;
    rand_bytes(0);
    clear_mon();
    pulse_start(8'h08);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (sel_arr[3] !== 4'hF) seen = 1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_wait: channel 4 never selected"); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (sel_arr[3] !== 4'hF || sel_flag !== 1'b1) begin n_bad++; $display("FAIL rstmid_sel: got %h required F", sel_arr[3]); end
    n_cmp++; if ({busy, rd_valid} !== 2'b00) begin n_bad++; $display("FAIL rstmid_status: got %b required 00", {busy, rd_valid}); end
    @(posedge clk); #1; reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_start_busy();
    rand_bytes(0);
    clear_mon();
    pulse_start(8'h12);
    repeat (10) @(posedge clk);
    pulse_start(8'hFF);
    wait_done("sbusy");
    build_exp(8'h12);
    check_results("sbusy");
    n_cmp++; if (busy_cyc !== exp_busy(2, 1)) begin n_bad++; $display("FAIL sbusy_cycles: got %0d required %0d", busy_cyc, exp_busy(2, 1)); end
  endtask

  task automatic test_start_at_done();
    bit seen;
    clear_mon();
    pulse_start(8'h00);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL sdone_timeout: done=0 required 1"); end
    start = 1'b1; chan_mask = 8'hFF;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || sel_flag !== 1'b1) begin n_bad++; $display("FAIL sdone_ignored%0d: busy=%b sel_flag=%b required 0/1", c, busy, sel_flag); end
    end
  endtask

  task automatic test_random();
    logic [7:0] m;
    bit sig_ok;
    for (int it = 0; it < 6; it++) begin
      rand_bytes(1);
      m = 8'($urandom);
      flag_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hAA;
      sig_ok = (flag_val == 8'hAA);
      rdy_rand = 1;
      clear_mon();
      pulse_start(m);
      wait_done("rand");
      if (sig_ok) build_exp(m); else begin exp_q.delete(); exp_fmt = 0; end
      check_results("rand");
      n_cmp++; if (sig_err !== !sig_ok) begin n_bad++; $display("FAIL rand_sig%0d: got %b required %b", it, sig_err, !sig_ok); end
      n_cmp++; if (fmt_err !== exp_fmt) begin n_bad++; $display("FAIL rand_fmt%0d: got %b required %b", it, fmt_err, exp_fmt); end
    end
    rdy_rand = 0;
    flag_val = 8'hAA;
  endtask

  initial begin
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 4; k++) bmem[n][k] = 8'h00;
    test_reset();
    test_single();
    test_sig_err();
    test_multi();
    test_mask_zero();
    test_fmt();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_start_at_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
